// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Time-multiplexed BCD driver for a multi-digit seven-segment display.
//   It captures a packed BCD value into a shadow register on load. A refresh
//   prescaler steps a digit index through 0..DIGITS-1. Each step presents one
//   decoded digit on the pads, with optional leading-zero blanking and
//   optional active-low output polarity.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   load       in   capture bcd into the shadow register on this edge
//   bcd        in   [4*DIGITS-1:0] packed BCD; nibble i drives digit i
//   segments   out  [6:0] segment drive, bit0=a .. bit6=g, registered
//   digit_sel  out  [DIGITS-1:0] one-hot digit enable, registered
//   frame      out  one-cycle pulse after the digit index wraps to 0
module seven_segment_mux #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned REFRESH_DIV   = 1000,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRE_TC   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // The inactive pad level doubles as the polarity mask.
  localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] SEL_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]       pres_q, pres_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                frame_q, frame_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic                tc;
  logic [3:0]          nib;
  logic                nz_above;
  logic                nz_at;
  logic                blank;
  logic [6:0]          seg_logic;
  logic [DIGITS-1:0]   sel_logic;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111100;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1100111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    shadow_d = load ? bcd : shadow_q;

    tc     = (pres_q == PRE_TC);
    pres_d = tc ? '0 : pres_q + 1'b1;

    idx_d   = idx_q;
    frame_d = 1'b0;
    if (tc) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        frame_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Walk from the most significant nibble down. nz_above then records
    // whether any nibble at or above the selected digit is non-zero.
    // Invalid codes count as non-zero, so they never trigger blanking.
    nib      = 4'd0;
    nz_above = 1'b0;
    nz_at    = 1'b0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      nz_above = nz_above | (shadow_q[4*j +: 4] != 4'd0);
      if (idx_q == IW'(j)) begin
        nib   = shadow_q[4*j +: 4];
        nz_at = nz_above;
      end
    end

    blank     = (BLANK_LEADING != 0) && (idx_q != '0) && !nz_at;
    seg_logic = blank ? 7'b0000000 : decode(nib);
    sel_logic = DIGITS'(1) << idx_q;

    seg_d = seg_logic ^ SEG_OFF;
    sel_d = sel_logic ^ SEL_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      pres_q   <= '0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      sel_q    <= SEL_OFF;
    end else begin
      shadow_q <= shadow_d;
      pres_q   <= pres_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign segments  = seg_q;
  assign digit_sel = sel_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] bcd;

  logic [6:0] seg_m, seg_a, seg_f;
  logic [3:0] sel_m, sel_a, sel_f;
  logic       frm_m, frm_a, frm_f;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] exp_m [4];
  logic [6:0] exp_a [4];

  always #5 clk = ~clk;

  // Main: active-high, blanking on, 3-cycle refresh.
  seven_segment_mux #(.DIGITS(4), .REFRESH_DIV(3), .ACTIVE_LOW(0), .BLANK_LEADING(1)) u_main (
    .clk(clk), .reset(reset), .load(load), .bcd(bcd),
    .segments(seg_m), .digit_sel(sel_m), .frame(frm_m));

  // Active-low, blanking off, same timing as main.
  seven_segment_mux #(.DIGITS(4), .REFRESH_DIV(3), .ACTIVE_LOW(1), .BLANK_LEADING(0)) u_al (
    .clk(clk), .reset(reset), .load(load), .bcd(bcd),
    .segments(seg_a), .digit_sel(sel_a), .frame(frm_a));

  // Advances every cycle.
  seven_segment_mux #(.DIGITS(4), .REFRESH_DIV(1), .ACTIVE_LOW(0), .BLANK_LEADING(1)) u_fast (
    .clk(clk), .reset(reset), .load(load), .bcd(bcd),
    .segments(seg_f), .digit_sel(sel_f), .frame(frm_f));

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Digit shown after edge cyc is floor(cyc/3) mod 4. The index wraps at
  // edges 11, 23, ..., so frame is high right after those edges.
  task automatic run_scan(input int n);
    int d;
    repeat (n) begin
      tick();
      d = (cyc / 3) % 4;
      check_val("main_sel",   sel_m, 1 << d);
      check_val("main_seg",   seg_m, exp_m[d]);
      check_val("main_frame", frm_m, (cyc % 12 == 11) ? 1 : 0);
      check_val("al_sel",     sel_a, (~(4'b0001 << d)) & 4'hF);
      check_val("al_seg",     seg_a, exp_a[d]);
      check_val("al_frame",   frm_a, (cyc % 12 == 11) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    bcd   = 16'h0000;
    repeat (3) tick();
    check_val("rst_main_seg",   seg_m, 7'h00);
    check_val("rst_main_sel",   sel_m, 4'h0);
    check_val("rst_main_frame", frm_m, 0);
    check_val("rst_al_seg",     seg_a, 7'h7F);
    check_val("rst_al_sel",     sel_a, 4'hF);

    // First cycle after release: digit 0 showing 0.
    reset = 1'b0;
    tick();
    check_val("rel_main_sel", sel_m, 4'b0001);
    check_val("rel_main_seg", seg_m, 7'b0111111);
    check_val("rel_al_sel",   sel_a, 4'b1110);
    check_val("rel_al_seg",   seg_a, 7'b1000000);
    check_val("rel_fast_seg", seg_f, 7'b0111111);

    // Re-align: reset, then release with a load of 1234 on the same edge.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load  = 1'b1;
    bcd   = 16'h1234;
    tick();
    cyc   = 0;
    load  = 1'b0;
    exp_m[0] = 7'b1100110; exp_m[1] = 7'b1001111;
    exp_m[2] = 7'b1011011; exp_m[3] = 7'b0000110;
    for (int i = 0; i < 4; i++) exp_a[i] = ~exp_m[i];
    run_scan(24);

    // 0007: leading zeros blank on main, shown as 0 on the unblanked unit.
    load = 1'b1; bcd = 16'h0007; tick(); load = 1'b0;
    exp_m[0] = 7'b0000111; exp_m[1] = 7'h00; exp_m[2] = 7'h00; exp_m[3] = 7'h00;
    exp_a[0] = ~7'b0000111; exp_a[1] = ~7'b0111111; exp_a[2] = ~7'b0111111; exp_a[3] = ~7'b0111111;
    run_scan(12);

    // 0000: only digit 0 lit on main; every digit shows 0 on the other.
    load = 1'b1; bcd = 16'h0000; tick(); load = 1'b0;
    exp_m[0] = 7'b0111111; exp_m[1] = 7'h00; exp_m[2] = 7'h00; exp_m[3] = 7'h00;
    for (int i = 0; i < 4; i++) exp_a[i] = ~7'b0111111;
    run_scan(12);

    // 00A5: the invalid nibble decodes blank, digit 0 shows 5.
    load = 1'b1; bcd = 16'h00A5; tick(); load = 1'b0;
    exp_m[0] = 7'b1101101; exp_m[1] = 7'h00; exp_m[2] = 7'h00; exp_m[3] = 7'h00;
    exp_a[0] = ~7'b1101101; exp_a[1] = 7'h7F; exp_a[2] = ~7'b0111111; exp_a[3] = ~7'b0111111;
    run_scan(12);

    // The fast unit advances every edge, so this load coincides with an
    // index step. Every digit of 9999 decodes to 9.
    load = 1'b1; bcd = 16'h9999; tick(); load = 1'b0;
    tick();
    check_val("coll_fast_seg", seg_f, 7'b1100111);

    // Reset mid-scan.
    reset = 1'b1;
    tick();
    check_val("mid_rst_main_seg", seg_m, 7'h00);
    check_val("mid_rst_main_sel", sel_m, 4'h0);
    check_val("mid_rst_fast_sel", sel_f, 4'h0);
    check_val("mid_rst_al_seg",   seg_a, 7'h7F);
    reset = 1'b0;
    tick();
    check_val("post_rst_main_sel", sel_m, 4'b0001);
    check_val("post_rst_main_seg", seg_m, 7'b0111111);
    check_val("post_rst_fast_sel", sel_f, 4'b0001);
    check_val("post_rst_fast_seg", seg_f, 7'b0111111);
    tick();
    // Shadow cleared: digit 1 is a leading zero and is blanked.
    check_val("post_rst_fast_sel1", sel_f, 4'b0010);
    check_val("post_rst_fast_seg1", seg_f, 7'h00);
    check_val("post_rst_al_seg",    seg_a, 7'b1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
